// File: rtl/fifo_rd_ser_pkg.sv
// Shared types and frame-length helper for the FIFO-to-serial consumer.
// Parity-bit support is compiled in when FIFO_RD_SER_PARITY_EN is defined.
package fifo_rd_ser_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

`ifdef FIFO_RD_SER_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    // Bit periods per frame; multiply by the latched period P for clocks.
    function automatic int frame_bits(input int data_w, input int stop_bits);
        return 1 + data_w + PAR_BITS + stop_bits;
    endfunction

endpackage

// File: rtl/ser_baud_cnt.sv
// Loadable bit-period down-counter; o_tick marks the last clock of a bit.
module ser_baud_cnt #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tick
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/fifo_rd_ser.sv
// Pops words from a show-ahead FIFO and sends each as an async serial frame.
// Optional even-parity bit after the data bits: define FIFO_RD_SER_PARITY_EN.
module fifo_rd_ser
    import fifo_rd_ser_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BAUD_W    = 16,
    parameter int STOP_BITS = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [BAUD_W-1:0] baud_div_i,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              rd_rdy_i,
    output logic              rd_o,
    output logic              tx_o,
    output logic              busy_o
);

    localparam int IDX_W = $clog2(DATA_W + STOP_BITS + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [DATA_W-1:0]  r_shift;
    logic [BAUD_W-1:0]  r_period_m1;
    logic [BAUD_W-1:0]  w_period_m1_new;
    logic [BAUD_W-1:0]  w_load_val;
    logic [IDX_W-1:0]   r_idx;
    logic               w_tick;
    logic               w_busy;
    logic               w_last_data;
    logic               w_last_stop;
    logic               w_stop_end;
    logic               w_pop;
    logic               w_load;
`ifdef FIFO_RD_SER_PARITY_EN
    logic               r_par;
`endif

    // A divisor of 0 behaves like 1 (one clock per bit).
    assign w_period_m1_new = (baud_div_i == '0) ? '0 : baud_div_i - 1'b1;
    assign w_busy          = (r_state != IDLE);
    assign w_last_data     = (r_idx == IDX_W'(DATA_W - 1));
    assign w_last_stop     = (r_idx == IDX_W'(STOP_BITS - 1));
    assign w_stop_end      = (r_state == STOP) && w_tick && w_last_stop;
    assign w_pop           = rd_rdy_i && ((r_state == IDLE) || w_stop_end);
    assign w_load          = w_pop || w_tick;
    assign w_load_val      = w_pop ? w_period_m1_new : r_period_m1;

    ser_baud_cnt #(
        .W (BAUD_W)
    ) u_baud_cnt (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_en       (w_busy),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tick     (w_tick)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (rd_rdy_i) w_state_next = START;
            START: if (w_tick) w_state_next = DATA;
            DATA: begin
                if (w_tick && w_last_data) begin
`ifdef FIFO_RD_SER_PARITY_EN
                    w_state_next = PAR;
`else
                    w_state_next = STOP;
`endif
                end
            end
`ifdef FIFO_RD_SER_PARITY_EN
            PAR:   if (w_tick) w_state_next = STOP;
`endif
            STOP:  if (w_stop_end) w_state_next = rd_rdy_i ? START : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_o   = w_pop;
        busy_o = w_busy;
        tx_o   = 1'b1;
        case (r_state)
            START: tx_o = 1'b0;
            DATA:  tx_o = r_shift[0];
`ifdef FIFO_RD_SER_PARITY_EN
            PAR:   tx_o = r_par;
`endif
            default: tx_o = 1'b1;
        endcase
    end

    // r_idx counts data bits in DATA and stop bits in STOP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_shift     <= '0;
            r_period_m1 <= '0;
            r_idx       <= '0;
`ifdef FIFO_RD_SER_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else if (w_pop) begin
            r_shift     <= rd_data_i;
            r_period_m1 <= w_period_m1_new;
            r_idx       <= '0;
`ifdef FIFO_RD_SER_PARITY_EN
            r_par       <= ^rd_data_i;
`endif
        end else if (w_tick) begin
            if (r_state == DATA) begin
                r_shift <= r_shift >> 1;
                r_idx   <= w_last_data ? '0 : r_idx + 1'b1;
            end else if (r_state == STOP) begin
                r_idx   <= w_last_stop ? '0 : r_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_ser.sv
// Directed bench for fifo_rd_ser: table of single frames plus hand-written
// back-to-back, idle, and mid-frame reset sequences.
module tb_fifo_rd_ser;

`ifdef FIFO_RD_SER_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = 16'd4;
    logic [7:0]  rd_data = 8'h00;
    logic        rd_rdy = 1'b0;
    logic        rd_o;
    logic        tx_o;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_rd_ser #(
        .DATA_W    (8),
        .BAUD_W    (16),
        .STOP_BITS (1)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .baud_div_i (baud_div),
        .rd_data_i  (rd_data),
        .rd_rdy_i   (rd_rdy),
        .rd_o       (rd_o),
        .tx_o       (tx_o),
        .busy_o     (busy_o)
    );

    // seq[i] is the i-th bit on the line without parity: {stop, data MSB..LSB, start}.
    typedef struct {
        logic [7:0]  data;
        logic [15:0] baud;
        int          p;
        logic [9:0]  seq;
        logic        par;
        bit          chg;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_frame(input vec_t v);
        logic [NB-1:0] fr;
`ifdef FIFO_RD_SER_PARITY_EN
        fr = {1'b1, v.par, v.seq[8:0]};
`else
        fr = v.seq;
`endif
        @(negedge clk);
        rd_data  = v.data;
        baud_div = v.baud;
        rd_rdy   = 1'b1;
        #1;
        chk("pop_strobe", 32'(rd_o), 32'd1);
        @(negedge clk);
        rd_rdy = 1'b0;
        #1;
        for (int b = 0; b < NB; b++) begin
            for (int k = 0; k < v.p; k++) begin
                if (v.chg && b == 2 && k == 0) baud_div = 16'd8;
                chk($sformatf("tx_d%02h_b%0d_k%0d", v.data, b, k), 32'(tx_o), 32'(fr[b]));
                chk("busy_in_frame", 32'(busy_o), 32'd1);
                chk("no_pop_in_frame", 32'(rd_o), 32'd0);
                tick();
            end
        end
        chk("tx_idle_after", 32'(tx_o), 32'd1);
        chk("busy_low_after", 32'(busy_o), 32'd0);
        $display("frame data=%02h baud=%0d bits=%0d clocks=%0d done", v.data, v.baud, NB, NB * v.p);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int L;
        int pops;
        int pop_c[2];

        vecs[0] = '{8'hA5, 16'd4, 4, 10'b1101001010, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 16'd0, 1, 10'b1000000010, 1'b1, 1'b1};
        vecs[2] = '{8'h3C, 16'd2, 2, 10'b1001111000, 1'b0, 1'b0};
        vecs[3] = '{8'h07, 16'd2, 2, 10'b1000001110, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 16'd1, 1, 10'b1111111110, 1'b0, 1'b0};

        // Reset values
        tick();
        chk("rst_tx", 32'(tx_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_rd", 32'(rd_o), 32'd0);
        rst = 1'b0;
        $display("reset released");

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // FIFO empty for 100 clocks
        rd_rdy = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            chk("empty_rd", 32'(rd_o), 32'd0);
            chk("empty_tx", 32'(tx_o), 32'd1);
            chk("empty_busy", 32'(busy_o), 32'd0);
        end
        $display("idle 100 clocks done");

        // Back-to-back: 0x00 then 0xFF, baud 4
        L = NB * 4;
        pops = 0;
        pop_c[0] = -1;
        pop_c[1] = -1;
        @(negedge clk);
        rd_data  = 8'h00;
        baud_div = 16'd4;
        rd_rdy   = 1'b1;
        #1;
        for (int c = 0; c <= 2 * L + 1; c++) begin
            if (rd_o) begin
                if (pops < 2) pop_c[pops] = c;
                pops++;
            end
            if (c >= 1 && c <= 2 * L) chk("b2b_busy", 32'(busy_o), 32'd1);
            if (c == 5)         chk("b2b_f1_bit0", 32'(tx_o), 32'd0);
            if (c == L)         chk("b2b_last_stop", 32'(tx_o), 32'd1);
            if (c == L + 1)     chk("b2b_next_start", 32'(tx_o), 32'd0);
            if (c == L + 5)     chk("b2b_f2_bit0", 32'(tx_o), 32'd1);
            if (c == 2 * L + 1) begin
                chk("b2b_end_busy", 32'(busy_o), 32'd0);
                chk("b2b_end_tx", 32'(tx_o), 32'd1);
            end
            @(negedge clk);
            if (c == 0) rd_data = 8'hFF;
            if (c == L) rd_rdy = 1'b0;
            #1;
        end
        chk("b2b_pop_count", 32'(pops), 32'd2);
        chk("b2b_pop0_at", 32'(pop_c[0]), 32'd0);
        chk("b2b_pop_gap", 32'(pop_c[1]), 32'(L));
        $display("back-to-back pops=%0d gap=%0d", pops, pop_c[1] - pop_c[0]);

        // Reset during data bit 3 of 0xA5
        @(negedge clk);
        rd_data  = 8'hA5;
        baud_div = 16'd4;
        rd_rdy   = 1'b1;
        #1;
        chk("rst_pop", 32'(rd_o), 32'd1);
        @(negedge clk);
        rd_rdy = 1'b0;
        repeat (4 + 12) @(negedge clk);
        #1;
        chk("pre_rst_bit3", 32'(tx_o), 32'd0);
        chk("pre_rst_busy", 32'(busy_o), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_tx", 32'(tx_o), 32'd1);
        chk("async_rst_busy", 32'(busy_o), 32'd0);
        chk("async_rst_rd", 32'(rd_o), 32'd0);
        tick();
        chk("rst_hold_tx", 32'(tx_o), 32'd1);
        rst = 1'b0;
        tick();
        chk("post_rst_tx", 32'(tx_o), 32'd1);
        chk("post_rst_rd", 32'(rd_o), 32'd0);
        $display("mid-frame reset done");
        run_frame(vecs[2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
